// File: rtl/ad9280_scope_intc_if.sv
// ad9280_scope_intc_if: AXI4-Lite slave bus bundle for the scope interrupt controller
// Ports: AW/W/B write channels and AR/R read channels; master drives requests, slave drives responses.
interface ad9280_scope_intc_if #(
  parameter int C_S_AXI_ADDR_WIDTH = 5
);
  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic [2:0]                    S_AXI_AWPROT;
  logic                          S_AXI_AWVALID;
  logic                          S_AXI_AWREADY;
  logic [31:0]                   S_AXI_WDATA;
  logic [3:0]                    S_AXI_WSTRB;
  logic                          S_AXI_WVALID;
  logic                          S_AXI_WREADY;
  logic [1:0]                    S_AXI_BRESP;
  logic                          S_AXI_BVALID;
  logic                          S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic [2:0]                    S_AXI_ARPROT;
  logic                          S_AXI_ARVALID;
  logic                          S_AXI_ARREADY;
  logic [31:0]                   S_AXI_RDATA;
  logic [1:0]                    S_AXI_RRESP;
  logic                          S_AXI_RVALID;
  logic                          S_AXI_RREADY;
  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/ad9280_scope_intc.sv
// ad9280_scope_intc: AXI4-Lite interrupt controller aggregating NUM_INTR scope events into one irq
// Ports: ACLK clock, ARESET sync active-high reset, intr_in event lines, irq request, s AXI4-Lite slave bus.
module ad9280_scope_intc #(
  parameter int NUM_INTR           = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int IRQ_SENSITIVITY    = 1,
  parameter int IRQ_ACTIVE_STATE   = 1
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [NUM_INTR-1:0] intr_in,
  output logic                irq,
  ad9280_scope_intc_if.slave  s
);
  localparam int   N     = NUM_INTR;
  localparam logic L_ACT = 1'(IRQ_ACTIVE_STATE);
  logic         r_awready, r_bvalid, r_arready, r_rvalid, r_gie, r_irq_int, r_irq_d;
  logic [31:0]  r_rdata, w_rmux, w_bm;
  logic [N-1:0] r_ier, r_status, r_mode, r_pol, r_prev;
  logic [N-1:0] w_wm, w_wd, w_ack, w_swi, w_act, w_det, w_pend;
  logic [2:0]   w_wa, w_ra;
  logic         w_wen, w_ren;
  logic         w_unused;
  assign w_unused = ^{s.S_AXI_AWPROT, s.S_AXI_ARPROT, s.S_AXI_AWADDR, s.S_AXI_ARADDR, s.S_AXI_WDATA, w_bm};
  assign w_bm  = {{8{s.S_AXI_WSTRB[3]}}, {8{s.S_AXI_WSTRB[2]}}, {8{s.S_AXI_WSTRB[1]}}, {8{s.S_AXI_WSTRB[0]}}};
  assign w_wm  = w_bm[N-1:0];
  assign w_wd  = s.S_AXI_WDATA[N-1:0] & w_wm;
  assign w_wa  = s.S_AXI_AWADDR[4:2];
  assign w_ra  = s.S_AXI_ARADDR[4:2];
  // READY is registered, so the handshake edge is the one where READY is already high
  assign w_wen = r_awready & s.S_AXI_AWVALID & s.S_AXI_WVALID;
  assign w_ren = r_arready & s.S_AXI_ARVALID;
  assign w_ack = (w_wen && w_wa == 3'd3) ? w_wd : '0;
  assign w_swi = (w_wen && w_wa == 3'd7) ? w_wd : '0;
  assign w_act = ~(intr_in ^ r_pol);
  // edge-mode bits need a fresh activation; level-mode bits detect whenever active
  assign w_det  = w_act & ~(r_mode & r_prev);
  assign w_pend = r_status & r_ier;
  always_comb begin
    w_rmux = '0;
    case (w_ra)
      3'd0: w_rmux = {31'b0, r_gie};
      3'd1: w_rmux = 32'(r_ier);
      3'd2: w_rmux = 32'(r_status);
      3'd4: w_rmux = 32'(w_pend);
      3'd5: w_rmux = 32'(r_mode);
      3'd6: w_rmux = 32'(r_pol);
      default: w_rmux = '0;
    endcase
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_gie     <= 1'b0;
      r_ier     <= '0;
      r_status  <= '0;
      r_mode    <= '0;
      r_pol     <= '1;
      r_prev    <= '1;
      r_irq_int <= 1'b0;
      r_irq_d   <= 1'b0;
    end else begin
      r_awready <= s.S_AXI_AWVALID & s.S_AXI_WVALID & ~r_bvalid & ~r_awready;
      r_bvalid  <= w_wen | (r_bvalid & ~s.S_AXI_BREADY);
      r_arready <= s.S_AXI_ARVALID & ~r_rvalid & ~r_arready;
      r_rvalid  <= w_ren | (r_rvalid & ~s.S_AXI_RREADY);
      if (w_ren) r_rdata <= w_rmux;
      if (w_wen && w_wa == 3'd0 && s.S_AXI_WSTRB[0]) r_gie <= s.S_AXI_WDATA[0];
      if (w_wen && w_wa == 3'd1) r_ier <= (r_ier & ~w_wm) | w_wd;
      if (w_wen && w_wa == 3'd5) r_mode <= (r_mode & ~w_wm) | w_wd;
      if (w_wen && w_wa == 3'd6) r_pol <= (r_pol & ~w_wm) | w_wd;
      r_prev    <= w_act;
      r_status  <= (r_status & ~w_ack) | w_det | w_swi;
      r_irq_int <= r_gie & |w_pend;
      r_irq_d   <= r_irq_int;
    end
  end
  assign irq = ((IRQ_SENSITIVITY != 0) ? r_irq_int : (r_irq_int & ~r_irq_d)) ? L_ACT : ~L_ACT;
  assign s.S_AXI_AWREADY = r_awready;
  assign s.S_AXI_WREADY  = r_awready;
  assign s.S_AXI_BVALID  = r_bvalid;
  assign s.S_AXI_BRESP   = 2'b00;
  assign s.S_AXI_ARREADY = r_arready;
  assign s.S_AXI_RVALID  = r_rvalid;
  assign s.S_AXI_RDATA   = r_rdata;
  assign s.S_AXI_RRESP   = 2'b00;
endmodule

// File: tb/tb_ad9280_scope_intc.sv
// tb_ad9280_scope_intc: table-driven and scoreboard bench for the level and pulse builds of the controller
module tb_ad9280_scope_intc;
  logic       ACLK = 1'b0, ARESET, irq, irq_p, mon_clr;
  logic [3:0] intr_in;
  int         pass = 0, total = 0, low_cnt, p_cnt;
  logic [31:0] exp_q[$];
  string       nm_q[$];
  typedef struct {logic wr; logic [4:0] a; logic [31:0] d; logic [3:0] st; logic [31:0] e;} vec_t;
  vec_t v[$];
  always #5 ACLK = ~ACLK;
  ad9280_scope_intc_if #(.C_S_AXI_ADDR_WIDTH(5)) ifl ();
  ad9280_scope_intc_if #(.C_S_AXI_ADDR_WIDTH(5)) ifp ();
  assign ifp.S_AXI_AWADDR  = ifl.S_AXI_AWADDR;
  assign ifp.S_AXI_AWPROT  = ifl.S_AXI_AWPROT;
  assign ifp.S_AXI_AWVALID = ifl.S_AXI_AWVALID;
  assign ifp.S_AXI_WDATA   = ifl.S_AXI_WDATA;
  assign ifp.S_AXI_WSTRB   = ifl.S_AXI_WSTRB;
  assign ifp.S_AXI_WVALID  = ifl.S_AXI_WVALID;
  assign ifp.S_AXI_BREADY  = ifl.S_AXI_BREADY;
  assign ifp.S_AXI_ARADDR  = ifl.S_AXI_ARADDR;
  assign ifp.S_AXI_ARPROT  = ifl.S_AXI_ARPROT;
  assign ifp.S_AXI_ARVALID = ifl.S_AXI_ARVALID;
  assign ifp.S_AXI_RREADY  = ifl.S_AXI_RREADY;
  ad9280_scope_intc #(.NUM_INTR(4), .IRQ_SENSITIVITY(1), .IRQ_ACTIVE_STATE(1)) u_dut (
    .ACLK(ACLK), .ARESET(ARESET), .intr_in(intr_in), .irq(irq), .s(ifl.slave));
  ad9280_scope_intc #(.NUM_INTR(4), .IRQ_SENSITIVITY(0), .IRQ_ACTIVE_STATE(1)) u_dut_p (
    .ACLK(ACLK), .ARESET(ARESET), .intr_in(intr_in), .irq(irq_p), .s(ifp.slave));
  always @(negedge ACLK) begin
    if (mon_clr) begin
      low_cnt <= 0;
      p_cnt   <= 0;
    end else begin
      if (!irq) low_cnt <= low_cnt + 1;
      if (irq_p) p_cnt <= p_cnt + 1;
    end
  end
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %0h, want %0h", n, a, e);
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] st);
    int k = 0;
    ifl.S_AXI_AWADDR = a; ifl.S_AXI_WDATA = d; ifl.S_AXI_WSTRB = st;
    ifl.S_AXI_AWVALID = 1'b1; ifl.S_AXI_WVALID = 1'b1; ifl.S_AXI_BREADY = 1'b1;
    do begin @(negedge ACLK); k++; end while (!ifl.S_AXI_AWREADY && k < 50);
    @(posedge ACLK); #1;
    ifl.S_AXI_AWVALID = 1'b0; ifl.S_AXI_WVALID = 1'b0;
    chk($sformatf("wr %0h bvalid/bresp", a), {ifl.S_AXI_BVALID, ifl.S_AXI_BRESP}, 3'b100);
    @(posedge ACLK); #1;
  endtask
  task automatic rd(input logic [4:0] a, input logic [31:0] e, input string n);
    int k = 0;
    exp_q.push_back(e); nm_q.push_back(n);
    ifl.S_AXI_ARADDR = a; ifl.S_AXI_ARVALID = 1'b1; ifl.S_AXI_RREADY = 1'b1;
    do begin @(negedge ACLK); k++; end while (!ifl.S_AXI_ARREADY && k < 50);
    @(posedge ACLK); #1;
    ifl.S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    chk(nm_q.pop_front(), {ifl.S_AXI_RVALID, ifl.S_AXI_RRESP, ifl.S_AXI_RDATA}, {3'b100, exp_q.pop_front()});
    @(posedge ACLK); #1;
  endtask
  task automatic mon_reset();
    mon_clr = 1'b1;
    @(posedge ACLK); #1;
    mon_clr = 1'b0;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int k, aw_cnt, bv_cnt;
    ARESET = 1'b1; intr_in = 4'h0; mon_clr = 1'b1;
    ifl.S_AXI_AWADDR = '0; ifl.S_AXI_AWPROT = '0; ifl.S_AXI_AWVALID = 1'b0;
    ifl.S_AXI_WDATA = '0; ifl.S_AXI_WSTRB = '0; ifl.S_AXI_WVALID = 1'b0; ifl.S_AXI_BREADY = 1'b1;
    ifl.S_AXI_ARADDR = '0; ifl.S_AXI_ARPROT = '0; ifl.S_AXI_ARVALID = 1'b0; ifl.S_AXI_RREADY = 1'b1;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0; mon_clr = 1'b0;
    @(negedge ACLK);
    chk("reset outputs", {irq, irq_p, ifl.S_AXI_AWREADY, ifl.S_AXI_WREADY, ifl.S_AXI_BVALID,
                          ifl.S_AXI_ARREADY, ifl.S_AXI_RVALID, ifl.S_AXI_RDATA}, 39'h0);
    @(posedge ACLK); #1;
    v.push_back('{1'b0, 5'h00, 32'h0, 4'h0, 32'h0});
    v.push_back('{1'b0, 5'h04, 32'h0, 4'h0, 32'h0});
    v.push_back('{1'b0, 5'h08, 32'h0, 4'h0, 32'h0});
    v.push_back('{1'b0, 5'h0C, 32'h0, 4'h0, 32'h0});
    v.push_back('{1'b0, 5'h10, 32'h0, 4'h0, 32'h0});
    v.push_back('{1'b0, 5'h14, 32'h0, 4'h0, 32'h0});
    v.push_back('{1'b0, 5'h18, 32'h0, 4'h0, 32'hF});
    v.push_back('{1'b0, 5'h1C, 32'h0, 4'h0, 32'h0});
    v.push_back('{1'b1, 5'h04, 32'hFFFF_FFFF, 4'h1, 32'h0});
    v.push_back('{1'b0, 5'h04, 32'h0, 4'h0, 32'hF});
    v.push_back('{1'b1, 5'h18, 32'h0, 4'h2, 32'h0});
    v.push_back('{1'b0, 5'h18, 32'h0, 4'h0, 32'hF});
    v.push_back('{1'b1, 5'h00, 32'hFF, 4'hF, 32'h0});
    v.push_back('{1'b0, 5'h00, 32'h0, 4'h0, 32'h1});
    v.push_back('{1'b1, 5'h00, 32'h0, 4'hE, 32'h0});
    v.push_back('{1'b0, 5'h00, 32'h0, 4'h0, 32'h1});
    v.push_back('{1'b1, 5'h14, 32'h5, 4'hF, 32'h0});
    v.push_back('{1'b0, 5'h14, 32'h0, 4'h0, 32'h5});
    v.push_back('{1'b1, 5'h0C, 32'hF, 4'hF, 32'h0});
    v.push_back('{1'b0, 5'h0C, 32'h0, 4'h0, 32'h0});
    v.push_back('{1'b0, 5'h08, 32'h0, 4'h0, 32'h0});
    v.push_back('{1'b1, 5'h14, 32'h0, 4'hF, 32'h0});
    v.push_back('{1'b1, 5'h00, 32'h0, 4'h1, 32'h0});
    v.push_back('{1'b1, 5'h04, 32'h0, 4'hF, 32'h0});
    for (int i = 0; i < v.size(); i++)
      if (v[i].wr) wr(v[i].a, v[i].d, v[i].st);
      else rd(v[i].a, v[i].e, $sformatf("vec%0d rd %0h", i, v[i].a));
    wr(5'h00, 32'h1, 4'hF);
    wr(5'h04, 32'h1, 4'hF);
    @(negedge ACLK) intr_in[0] = 1'b1;
    @(negedge ACLK) intr_in[0] = 1'b0;
    chk("irq not yet after edge n", irq, 1'b0);
    @(negedge ACLK);
    chk("irq after edge n+1", irq, 1'b1);
    @(posedge ACLK); #1;
    rd(5'h10, 32'h1, "pend after pulse");
    wr(5'h0C, 32'h1, 4'hF);
    chk("irq after ack", irq, 1'b0);
    rd(5'h10, 32'h0, "pend after ack");
    wr(5'h14, 32'h2, 4'hF);
    intr_in[1] = 1'b1;
    repeat (5) @(posedge ACLK); #1;
    rd(5'h08, 32'h2, "edge hold status");
    wr(5'h0C, 32'h2, 4'hF);
    repeat (5) @(posedge ACLK); #1;
    rd(5'h08, 32'h0, "edge no refire after ack");
    intr_in[1] = 1'b0;
    repeat (2) @(posedge ACLK); #1;
    rd(5'h08, 32'h0, "edge falling no detect");
    wr(5'h18, 32'hD, 4'hF);
    rd(5'h08, 32'h2, "pol change edge captured");
    wr(5'h18, 32'hF, 4'hF);
    wr(5'h0C, 32'h2, 4'hF);
    rd(5'h08, 32'h0, "status after pol restore");
    wr(5'h14, 32'h0, 4'hF);
    intr_in[0] = 1'b1;
    repeat (3) @(posedge ACLK); #1;
    chk("level held irq", irq, 1'b1);
    mon_reset();
    wr(5'h0C, 32'h1, 4'hF);
    repeat (3) @(posedge ACLK); #1;
    rd(5'h08, 32'h1, "level refire status");
    chk("level irq low cycles le 1", low_cnt <= 1, 1'b1);
    intr_in[0] = 1'b0;
    wr(5'h0C, 32'h1, 4'hF);
    rd(5'h08, 32'h0, "level cleared after release");
    chk("irq after level release", irq, 1'b0);
    wr(5'h04, 32'h0, 4'hF);
    wr(5'h1C, 32'h8, 4'hF);
    rd(5'h08, 32'h8, "swi status");
    rd(5'h10, 32'h0, "swi pend masked");
    chk("swi irq masked", irq, 1'b0);
    wr(5'h04, 32'h8, 4'hF);
    chk("swi irq enabled", irq, 1'b1);
    wr(5'h00, 32'h0, 4'hF);
    chk("gie off irq", irq, 1'b0);
    wr(5'h0C, 32'h8, 4'hF);
    rd(5'h08, 32'h0, "swi acked");
    wr(5'h00, 32'h1, 4'hF);
    wr(5'h04, 32'hF, 4'hF);
    mon_reset();
    intr_in[0] = 1'b1;
    @(posedge ACLK); #1 intr_in[0] = 1'b0;
    repeat (5) @(posedge ACLK); #1 intr_in[2] = 1'b1;
    @(posedge ACLK); #1 intr_in[2] = 1'b0;
    repeat (10) @(posedge ACLK); #1;
    chk("pulse build single pulse", p_cnt, 1);
    chk("level build still high", irq, 1'b1);
    rd(5'h08, 32'h5, "two sources status");
    ifl.S_AXI_AWADDR = 5'h04; ifl.S_AXI_WDATA = 32'h3; ifl.S_AXI_WSTRB = 4'hF;
    ifl.S_AXI_AWVALID = 1'b1; ifl.S_AXI_WVALID = 1'b1; ifl.S_AXI_BREADY = 1'b0;
    k = 0;
    do begin @(negedge ACLK); k++; end while (!ifl.S_AXI_AWREADY && k < 50);
    @(posedge ACLK); #1;
    ifl.S_AXI_WDATA = 32'h5;
    aw_cnt = 0; bv_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      aw_cnt += int'(ifl.S_AXI_AWREADY);
      bv_cnt += int'(ifl.S_AXI_BVALID);
    end
    chk("no accept while bvalid pending", aw_cnt, 0);
    chk("bvalid held without bready", bv_cnt, 10);
    @(posedge ACLK); #1;
    rd(5'h04, 32'h3, "ier first write only");
    ifl.S_AXI_BREADY = 1'b1;
    k = 0;
    do begin @(negedge ACLK); k++; end while (!ifl.S_AXI_AWREADY && k < 50);
    @(posedge ACLK); #1;
    ifl.S_AXI_AWVALID = 1'b0; ifl.S_AXI_WVALID = 1'b0;
    chk("second write bvalid", ifl.S_AXI_BVALID, 1'b1);
    @(posedge ACLK); #1;
    rd(5'h04, 32'h5, "ier second write");
    ifl.S_AXI_ARADDR = 5'h18; ifl.S_AXI_ARVALID = 1'b1; ifl.S_AXI_RREADY = 1'b0;
    k = 0;
    do begin @(negedge ACLK); k++; end while (!ifl.S_AXI_ARREADY && k < 50);
    @(posedge ACLK); #1;
    ifl.S_AXI_ARVALID = 1'b0;
    chk("rvalid before reset", {ifl.S_AXI_RVALID, ifl.S_AXI_RDATA}, {1'b1, 32'hF});
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    chk("reset drops rvalid and irq", {ifl.S_AXI_RVALID, irq}, 2'b00);
    ARESET = 1'b0; ifl.S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    rd(5'h08, 32'h0, "status after mid reset");
    rd(5'h00, 32'h0, "gie after mid reset");
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
